// File: rtl/uio_bus_scheduler.sv
// Arbitrates the bidirectional uio pad bus between a write requester and a read
// requester, inserting turnaround idle cycles on direction changes with round-robin hold limits.
module uio_bus_scheduler #(
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshake: wr_req/rd_req are levels held while a beat is wanted; each
    // completed beat is reported by exactly one cycle of wr_ack or rd_valid.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_e;

    localparam logic       DIR_READ  = 1'b0;
    localparam logic       DIR_WRITE = 1'b1;
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic       bus_dir_q, bus_dir_d;
    logic       last_winner_q, last_winner_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] uio_oe_q, uio_oe_d;
    logic [7:0] uio_out_q, uio_out_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_valid_q, rd_valid_d;

    logic       win_wr;
    logic       wr_beat;
    logic       rd_beat;
    logic [7:0] beat_inc;

    // On a tie the requester that did not win last time gets the bus.
    assign win_wr   = wr_req && (!rd_req || (last_winner_q == DIR_READ));
    assign wr_beat  = (state_q == S_WRITE) && wr_req;
    assign rd_beat  = (state_q == S_READ) && rd_req;
    assign beat_inc = (beat_cnt_q == HOLD_MAX) ? beat_cnt_q : beat_cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bus_dir_q     <= DIR_READ;
            last_winner_q <= DIR_READ;
            turn_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            uio_oe_q      <= '0;
            uio_out_q     <= '0;
            rd_data_q     <= '0;
            wr_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_dir_q     <= bus_dir_d;
            last_winner_q <= last_winner_d;
            turn_cnt_q    <= turn_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            uio_oe_q      <= uio_oe_d;
            uio_out_q     <= uio_out_d;
            rd_data_q     <= rd_data_d;
            wr_ack_q      <= wr_ack_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        bus_dir_d     = bus_dir_q;
        last_winner_d = last_winner_q;
        turn_cnt_d    = turn_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_req || rd_req) begin
                    last_winner_d = win_wr ? DIR_WRITE : DIR_READ;
                    if ((win_wr ? DIR_WRITE : DIR_READ) == bus_dir_q) begin
                        state_d = win_wr ? S_WRITE : S_READ;
                    end else begin
                        state_d    = S_TURN;
                        bus_dir_d  = win_wr ? DIR_WRITE : DIR_READ;
                        turn_cnt_d = TURN_LOAD;
                    end
                end
            end
            S_TURN: begin
                // The granted state is entered even if its request has gone away.
                if (turn_cnt_q <= 4'd1) begin
                    state_d    = (bus_dir_q == DIR_WRITE) ? S_WRITE : S_READ;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                if (!wr_req) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                end else if ((beat_inc == HOLD_MAX) && rd_req) begin
                    state_d       = S_TURN;
                    bus_dir_d     = DIR_READ;
                    last_winner_d = DIR_READ;
                    turn_cnt_d    = TURN_LOAD;
                    beat_cnt_d    = '0;
                end else begin
                    beat_cnt_d = beat_inc;
                end
            end
            S_READ: begin
                if (!rd_req) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                end else if ((beat_inc == HOLD_MAX) && wr_req) begin
                    state_d       = S_TURN;
                    bus_dir_d     = DIR_WRITE;
                    last_winner_d = DIR_WRITE;
                    turn_cnt_d    = TURN_LOAD;
                    beat_cnt_d    = '0;
                end else begin
                    beat_cnt_d = beat_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs are computed from the next state so the
    // pad enable always matches the state occupied in the same cycle.
    always_comb begin
        uio_oe_d   = 8'h00;
        uio_out_d  = uio_out_q;
        rd_data_d  = rd_data_q;
        wr_ack_d   = wr_beat;
        rd_valid_d = rd_beat;
        if ((state_d == S_WRITE) || ((state_d == S_IDLE) && (bus_dir_d == DIR_WRITE))) begin
            uio_oe_d = 8'hFF;
        end
        if (wr_beat) begin
            uio_out_d = wr_data;
        end
        if (rd_beat) begin
            rd_data_d = uio_in;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign uio_out   = uio_out_q;
    assign uio_oe    = uio_oe_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_ack_q && rd_valid_q));

    a_no_drive_after_read: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid_q |-> (uio_oe_q == 8'h00));

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Bench for uio_bus_scheduler: directed scenarios plus random request traffic,
// checked against a rule-level reference model through expected-data queues.
module tb_uio_bus_scheduler;

  localparam int TB_TURN = 1;
  localparam int TB_HOLD = 4;

  localparam int M_IDLE = 0;
  localparam int M_TURN = 1;
  localparam int M_WR   = 2;
  localparam int M_RD   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  logic [7:0] wr_exp_q[$];
  logic [7:0] rd_exp_q[$];

  // reference model state
  int         m_mode;
  bit         m_dir_wr;
  bit         m_last_wr;
  int         m_turn_left;
  int         m_hold;
  logic [7:0] m_uio_out;
  bit         exp_wr_ack;
  bit         exp_rd_valid;

  uio_bus_scheduler #(.TURN_CYC(TB_TURN), .MAX_HOLD(TB_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_dir_wr = 1'b0;
    m_last_wr = 1'b0;
    m_turn_left = 0;
    m_hold = 0;
    m_uio_out = 8'h00;
    exp_wr_ack = 1'b0;
    exp_rd_valid = 1'b0;
    wr_exp_q.delete();
    rd_exp_q.delete();
  endtask

  // one clock edge of the arbitration rules
  task automatic model_step();
    bit wr;
    bit rd;
    bit pick_wr;
    wr = wr_req;
    rd = rd_req;
    exp_wr_ack = 1'b0;
    exp_rd_valid = 1'b0;
    if (m_mode == M_IDLE) begin
      if (wr || rd) begin
        pick_wr = wr && (!rd || !m_last_wr);
        m_last_wr = pick_wr;
        if (pick_wr == m_dir_wr) begin
          m_mode = pick_wr ? M_WR : M_RD;
        end else begin
          m_dir_wr = pick_wr;
          m_mode = M_TURN;
          m_turn_left = TB_TURN;
        end
      end
    end else if (m_mode == M_TURN) begin
      m_turn_left--;
      if (m_turn_left == 0) m_mode = m_dir_wr ? M_WR : M_RD;
    end else begin
      // a data phase: own request gone means leave without a beat
      if ((m_mode == M_WR && !wr) || (m_mode == M_RD && !rd)) begin
        m_mode = M_IDLE;
        m_hold = 0;
      end else begin
        if (m_mode == M_WR) begin
          m_uio_out = wr_data;
          exp_wr_ack = 1'b1;
          wr_exp_q.push_back(wr_data);
        end else begin
          exp_rd_valid = 1'b1;
          rd_exp_q.push_back(uio_in);
        end
        if (m_hold < TB_HOLD) m_hold++;
        if (m_hold == TB_HOLD && ((m_mode == M_WR) ? rd : wr)) begin
          m_dir_wr = (m_mode == M_RD);
          m_last_wr = m_dir_wr;
          m_mode = M_TURN;
          m_turn_left = TB_TURN;
          m_hold = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("uio_oe", uio_oe,
              (m_mode == M_WR || (m_mode == M_IDLE && m_dir_wr)) ? 32'hFF : 32'h00);
        check("busy", busy, (m_mode != M_IDLE) ? 32'd1 : 32'd0);
        check("wr_ack", wr_ack, exp_wr_ack);
        check("rd_valid", rd_valid, exp_rd_valid);
        check("uio_out", uio_out, m_uio_out);
        if (wr_ack) begin
          wr_pulses++;
          if (wr_exp_q.size() == 0) check("wr_q_nonempty", 0, 1);
          else check("wr_data_out", uio_out, wr_exp_q.pop_front());
        end
        if (rd_valid) begin
          rd_pulses++;
          if (rd_exp_q.size() == 0) check("rd_q_nonempty", 0, 1);
          else check("rd_data", rd_data, rd_exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd_tbl[4];
    int base;
    rd_tbl[0] = 8'h00; rd_tbl[1] = 8'h11; rd_tbl[2] = 8'h22; rd_tbl[3] = 8'h33;
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_data = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("reset_oe", uio_oe, 32'h00);
    check("reset_out", uio_out, 32'h00);
    check("reset_rd_data", rd_data, 32'h00);
    check("reset_busy", busy, 32'd0);

    // three reads, bus already facing read
    base = rd_pulses;
    for (int i = 0; i < 4; i++) begin
      uio_in = rd_tbl[i];
      rd_req = 1'b1;
      @(negedge clk);
    end
    idle_cycles(3);
    check("read3_count", rd_pulses - base, 32'd3);
    check("read3_last", rd_data, 32'h33);

    // single write from reset, needs one turnaround
    do_reset();
    base = wr_pulses;
    wr_data = 8'hA5;
    wr_req = 1'b1;
    repeat (3) @(negedge clk);
    idle_cycles(3);
    check("write_count", wr_pulses - base, 32'd1);
    check("write_out", uio_out, 32'hA5);
    check("write_idle_oe", uio_oe, 32'hFF);

    // both requesters held: alternating bursts
    do_reset();
    for (int i = 0; i < 40; i++) begin
      wr_req = 1'b1;
      rd_req = 1'b1;
      wr_data = 8'($urandom);
      uio_in = 8'($urandom);
      @(negedge clk);
    end
    idle_cycles(4);

    // write request dropped during turnaround
    do_reset();
    base = wr_pulses;
    wr_req = 1'b1;
    wr_data = 8'h5A;
    @(negedge clk);
    idle_cycles(4);
    check("drop_turn_acks", wr_pulses - base, 32'd0);
    check("drop_turn_oe", uio_oe, 32'hFF);

    // read-only stream: no yield
    do_reset();
    base = rd_pulses;
    for (int i = 0; i < 11; i++) begin
      rd_req = 1'b1;
      uio_in = 8'($urandom);
      @(negedge clk);
    end
    idle_cycles(3);
    check("rd_only_count", rd_pulses - base, 32'd10);

    // reset asserted mid-write releases pads without a clock edge
    do_reset();
    wr_req = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", uio_oe, 32'h00);
    check("async_rst_ack", wr_ack, 32'd0);
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) wr_req = ~wr_req;
      if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
      wr_data = 8'($urandom);
      uio_in = 8'($urandom);
      @(negedge clk);
    end
    idle_cycles(6);
    check("wr_q_drained", wr_exp_q.size(), 32'd0);
    check("rd_q_drained", rd_exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
